pdm_audio_tx: RTL and testbench

//  Playback-side counterpart of the microphone PDM decimator. It accepts 8-bit signed audio samples
//  (12 kHz nominal) over a valid/ready handshake and buffers them in a small FIFO.
//  A first-order sigma-delta modulator turns them back into a 1-bit PDM stream at ~3.072 MHz
//  (98.3 MHz / 32) to drive the speaker/audio-out pin. The block sits between the recorder

---
 rtl/pdm_pkg.sv | 12 +
 rtl/sample_fifo.sv | 49 ++++
 rtl/pdm_audio_tx.sv | 83 ++++++++
 tb/tb_pdm_audio_tx.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/pdm_pkg.sv
// Constants and helpers shared by the PDM microphone decimator and the PDM playback modulator.
package pdm_pkg;

  localparam int PDM_STEP_PERIOD = 32;
  localparam int PDM_OVERSAMPLE  = 256;

  // Two's complement to offset binary: -128..127 maps onto 0..255.
  function automatic logic [7:0] to_offset_bin(input logic signed [7:0] s);
    return {~s[7], s[6:0]};
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO holding audio samples between the playback path and the modulator.
module sample_fifo #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 4,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic [AW:0]           count
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic                  do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage is not reset; count and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pdm_audio_tx.sv
// Playback PDM transmitter: sample FIFO feeding a first-order sigma-delta modulator.
module pdm_audio_tx
  import pdm_pkg::*;
#(
  parameter  int STEP_PERIOD = PDM_STEP_PERIOD,
  parameter  int OVERSAMPLE  = PDM_OVERSAMPLE,
  parameter  int FIFO_DEPTH  = 4,
  localparam int CW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              enable_in,
  input  logic signed [7:0] sample_in,
  input  logic              sample_valid_in,
  output logic              sample_ready_out,
  output logic              pdm_out,
  output logic              pdm_clk_out,
  output logic              underrun_out,
  output logic [CW-1:0]     fifo_count_out
);

  localparam int SW = $clog2(STEP_PERIOD);
  localparam int BW = $clog2(OVERSAMPLE);

  logic [SW-1:0]     step_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [7:0]        acc;
  logic signed [7:0] cur_sample, next_sample, x;
  logic [7:0]        head;
  logic [8:0]        sum;
  logic              full, empty, step, boundary, pop;

  sample_fifo #(.DATA_WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_in),
    .rst   (rst_in),
    .push  (sample_valid_in),
    .pop   (pop),
    .wdata (sample_in),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count_out)
  );

  assign sample_ready_out = ~full;
  assign step         = enable_in && (step_cnt == SW'(STEP_PERIOD - 1));
  assign boundary     = step && (bit_cnt == '0);
  assign pop          = boundary && !empty;
  assign underrun_out = boundary && empty;

  // The boundary step already modulates the new sample, so there is no one-sample lag.
  assign next_sample = empty ? 8'sh00 : $signed(head);
  assign x           = boundary ? next_sample : cur_sample;
  assign sum         = {1'b0, acc} + {1'b0, to_offset_bin(x)};

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      step_cnt    <= '0;
      bit_cnt     <= '0;
      acc         <= '0;
      cur_sample  <= '0;
      pdm_out     <= 1'b0;
      pdm_clk_out <= 1'b0;
    end else if (!enable_in) begin
      // cur_sample is kept; the abandoned sample is not resumed.
      step_cnt    <= '0;
      bit_cnt     <= '0;
      acc         <= '0;
      pdm_out     <= 1'b0;
      pdm_clk_out <= 1'b0;
    end else begin
      step_cnt    <= step ? '0 : step_cnt + 1'b1;
      pdm_clk_out <= (step_cnt < SW'(STEP_PERIOD / 2));
      if (step) begin
        bit_cnt <= bit_cnt + 1'b1;
        acc     <= sum[7:0];
        pdm_out <= sum[8];
      end
      if (boundary) cur_sample <= next_sample;
    end
  end

endmodule

// File: tb/tb_pdm_audio_tx.sv
// Directed bench for pdm_audio_tx: window ones-density, FIFO flow, underrun and reset behaviour.
module tb_pdm_audio_tx;

  localparam int SP  = 32;
  localparam int OS  = 256;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] sample;
  logic       valid;
  logic       ready;
  logic       pdm;
  logic       pdm_clk;
  logic       underrun;
  logic [2:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  pdm_audio_tx dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .enable_in        (enable),
    .sample_in        (sample),
    .sample_valid_in  (valid),
    .sample_ready_out (ready),
    .pdm_out          (pdm),
    .pdm_clk_out      (pdm_clk),
    .underrun_out     (underrun),
    .fifo_count_out   (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] val);
    @(negedge clk);
    sample = val;
    valid  = 1'b1;
    @(negedge clk);
    valid  = 1'b0;
  endtask

  // One OVERSAMPLE window. Step k occupies negedges 32k..32k+31 after the window start;
  // c==30 is the boundary cycle, c==31 follows the step edge where the new bit appears.
  task automatic run_window(input bit push_bnd, input logic [7:0] pval,
                            output int ones, output int unds, output int clkhi,
                            output logic [1:0] first2);
    ones = 0; unds = 0; clkhi = 0; first2 = 2'b00;
    for (int k = 0; k < OS; k++) begin
      for (int c = 0; c < SP; c++) begin
        @(negedge clk);
        unds  += int'(underrun);
        clkhi += int'(pdm_clk);
        if (k == 0 && push_bnd && c == 30) begin
          sample = pval;
          valid  = 1'b1;
        end
        if (c == 31) begin
          valid = 1'b0;
          ones += int'(pdm);
          if (k < 2) first2[k] = pdm;
        end
      end
    end
  endtask

  int         ones, unds, clkhi;
  logic [1:0] f2;

  initial begin
    rst = 1'b1; enable = 1'b0; sample = 8'h00; valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pdm", pdm, 0);
    chk("rst_pdm_clk", pdm_clk, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_count", count, 0);
    chk("rst_ready", ready, 1);
    rst = 1'b0;

    // Preload while disabled: the fifth push must be refused.
    push(8'h7F); push(8'h80); push(8'h00); push(8'h40);
    chk("full_ready", ready, 0);
    push(8'h7F);
    chk("full_count", count, 4);
    chk("dis_pdm_clk", pdm_clk, 0);

    enable = 1'b1;
    run_window(1'b0, 8'h00, ones, unds, clkhi, f2);
    chk("w0_ones_7f", ones, 255);
    chk("w0_underrun", unds, 0);
    chk("w0_count", count, 3);
    chk("w0_clk_high", clkhi, OS * SP / 2);
    run_window(1'b0, 8'h00, ones, unds, clkhi, f2);
    chk("w1_ones_80", ones, 0);
    chk("w1_count", count, 2);
    run_window(1'b0, 8'h00, ones, unds, clkhi, f2);
    chk("w2_ones_00", ones, 128);
    chk("w2_first_bits", f2, 2);
    chk("w2_underrun", unds, 0);
    run_window(1'b0, 8'h00, ones, unds, clkhi, f2);
    chk("w3_ones_40", ones, 192);
    chk("w3_count", count, 0);
    run_window(1'b0, 8'h00, ones, unds, clkhi, f2);
    chk("w4_ones_silence", ones, 128);
    chk("w4_underrun", unds, 1);
    chk("w4_first_bits", f2, 2);

    // Push on the same cycle as the pop.
    @(negedge clk);
    enable = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    push(8'h40); push(8'hC0);
    chk("pp_pre_count", count, 2);
    enable = 1'b1;
    run_window(1'b1, 8'h10, ones, unds, clkhi, f2);
    chk("pp_count_held", count, 2);
    chk("pp_w0_ones_40", ones, 192);
    run_window(1'b0, 8'h00, ones, unds, clkhi, f2);
    chk("pp_w1_ones_c0", ones, 64);
    chk("pp_w1_count", count, 1);
    run_window(1'b0, 8'h00, ones, unds, clkhi, f2);
    chk("pp_w2_ones_10", ones, 144);
    chk("pp_w2_underrun", unds, 0);

    // Asynchronous reset between clock edges while enabled with a non-empty FIFO.
    push(8'h55);
    repeat (5) @(negedge clk);
    chk("pre_rst_count", count, 1);
    chk("pre_rst_pdm_clk", pdm_clk, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_pdm", pdm, 0);
    chk("arst_pdm_clk", pdm_clk, 0);
    chk("arst_underrun", underrun, 0);
    chk("arst_count", count, 0);
    chk("arst_ready", ready, 1);
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", ready, 1);
    chk("post_rst_count", count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
